dms_sched: RTL
==============

Name: dms_sched

Overview:
- Round-robin scheduler for the shared 1-to-7 serial demultiplexer.
- Arbitrates between 7 requesters; each requester wants to send one W-bit word.
- Latches the winning word, drives the demux address, then shifts the word out LSB-first on the shared line.
- Sits between the requesting units and the demux; it is the only driver of the demux line and address.

Parameters:
- W, 8, word length in bits shifted per frame (legal 2..32).
- NCH, 7, number of channels/requesters (legal 2..8; demux address fixed at 3 bits).

Ports:
- clk  in  1  single clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel request, level; requester holds it until it sees ack.
- data_in  in  NCH*W  flattened words; channel c occupies bits [c*W +: W].
- ack  out  NCH  one-hot, one-cycle pulse in the cycle the word of that channel is captured.
- adr  out  3  demux address; holds the served channel for the whole frame.
- line  out  1  serial bit to the demux.
- busy  out  1  high in LOAD, SHIFT and GAP.
- done  out  1  one-cycle pulse concurrent with the last bit of a frame.

Behaviour:
- Reset values: state=IDLE, ack=0, adr=0, line=0, busy=0, done=0, shift register=0, bit counter=0, last-served pointer=NCH-1 (channel 0 wins first).
- Reset mid-frame aborts the frame immediately and discards it; no done pulse is issued.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick channel c = first requesting channel scanning last+1, last+2, … modulo NCH.
  - Register adr<=c, shreg<=data_in[c], ack<=onehot(c), cnt<=0; go to LOAD.
  - ack is therefore high for exactly the LOAD cycle.
- LOAD: one cycle, busy=1, line=0; go to SHIFT.
- SHIFT: W cycles.
  - Each cycle line=shreg[0]; at the clock edge shreg>>=1 and cnt++.
  - done=1 in the cycle where cnt==W-1; at that edge go to GAP.
- GAP: one cycle.
  - line=0, busy=1, last<=adr; go to IDLE.
  - adr keeps its value until the next capture.
- Latency: req seen at IDLE edge k gives ack during cycle k+1, bit0 on line in cycle k+2, last bit in cycle k+W+1.
- Frame period: W+3 cycles from one IDLE to the next when requests are back-to-back.
- Outputs:
  - line and done are registered or decoded from registered state only; no combinational path from req/data_in to line/adr.
  - req is ignored outside IDLE.
  - data_in is sampled only at the capture edge; later changes do not affect the frame.
- Fairness: a channel served in frame n has the lowest priority in frame n+1, so every requester with req held is served within NCH frames.
- Boundaries:
  - Pointer wrap is NCH-1 -> 0.
  - Channels >= NCH never win.
  - req dropping mid-frame has no effect on the frame.
  - All-ones and all-zeros words shift unchanged.
  - A single persistent requester is re-served every W+3 cycles.

Decomposition:
- Package dms_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, GAP}
  - localparam AW=3
  - default NCH=7 and W=8
  - the onehot function
- One natural sub-module: dms_rr_pick, a combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: any, idx[2:0].
- The FSM, shift register and counter stay in dms_sched.

Test Plan:
- Reset, then req=0 for 20 cycles -> ack=0, busy=0, line=0, adr=0 throughout.
- req=0000100 with channel-2 word 8'hA5 -> ack=0000100 for 1 cycle; adr=2; line=1,0,1,0,0,1,0,1 on consecutive cycles; done on the 8th bit; busy drops after GAP.
- req=1111111 held with words equal to the channel index -> service order 0,1,2,3,4,5,6,0; each frame 11 cycles apart; adr matches the order.
- Serving channel 6, then req=1000001 -> channel 0 served next (pointer wrap); then channel 6.
- rst asserted in SHIFT after 3 bits of 8'hFF -> next cycle all outputs at reset values, no done; channel 0 wins the next arbitration.
- Change data_in and drop req during SHIFT -> transmitted bits equal the captured word; frame completes with done.

Source files
------------

// File: rtl/dms_pkg.sv
// Shared types and helpers for the demux scheduler: FSM states, address width,
// default sizing and the one-hot decoder used for the ack pulse.
package dms_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam int AW      = 3;
  localparam int DEF_NCH = 7;
  localparam int DEF_W   = 8;

  function automatic logic [(1<<AW)-1:0] onehot(input logic [AW-1:0] idx);
    logic [(1<<AW)-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dms_sched_if.sv
// Requester/demux-side bundle of the scheduler. The master modport is the
// scheduler itself; the slave modport is the requesters plus the demux.
interface dms_sched_if import dms_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W
);

  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] data_in;
  logic [NCH-1:0]   ack;
  logic [AW-1:0]    adr;
  logic             line;
  logic             busy;
  logic             done;

  modport master (input req, data_in, output ack, adr, line, busy, done);
  modport slave  (output req, data_in, input ack, adr, line, busy, done);

endinterface

// File: rtl/dms_rr_pick.sv
// Combinational round-robin picker: first requesting channel after 'last',
// wrapping modulo NCH.
module dms_rr_pick import dms_pkg::*; #(
  parameter int NCH = DEF_NCH
) (
  input  logic [NCH-1:0] req,
  input  logic [AW-1:0]  last,
  output logic           any,
  output logic [AW-1:0]  idx
);

  logic [AW-1:0] c;

  // Scan from the far end so the earliest hit in scan order is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int i = NCH; i >= 1; i--) begin
      c = AW'((int'(last) + i) % NCH);
      if (req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/dms_sched.sv
// Round-robin scheduler for the shared 1-to-NCH serial demux: captures one
// requester's word, holds the demux address and shifts the word out LSB-first.
module dms_sched import dms_pkg::*; #(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W
) (
  input logic        clk,
  input logic        rst,
  dms_sched_if.master bus
);

  localparam int CW = $clog2(W);

  state_t         state;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  last;
  logic [NCH-1:0] ack_q;
  logic [AW-1:0]  adr_q;
  logic           busy_q;
  logic           pick_any;
  logic [AW-1:0]  pick_idx;

  dms_rr_pick #(.NCH(NCH)) u_pick (
    .req  (bus.req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Pointer resets to the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      last   <= AW'(NCH - 1);
      ack_q  <= '0;
      adr_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            adr_q  <= pick_idx;
            shreg  <= bus.data_in[int'(pick_idx)*W +: W];
            ack_q  <= NCH'(onehot(pick_idx));
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: state <= SHIFT;
        SHIFT: begin
          shreg <= shreg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= GAP;
        end
        GAP: begin
          last   <= adr_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack  = ack_q;
  assign bus.adr  = adr_q;
  assign bus.busy = busy_q;
  assign bus.line = (state == SHIFT) & shreg[0];
  assign bus.done = (state == SHIFT) && (cnt == CW'(W - 1));

endmodule
